// File: rtl/serial_sub.sv
// Bit-serial a-b, LSB first, one half-subtractor pair per clock; done WIDTH edges after the start edge.
// No backpressure: start is honoured only in IDLE, ignored (not queued) while busy.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             d_ser,
  output logic             d_ser_valid
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_bout;
  logic             r_dser;
  logic             r_dv;

  logic w_x;
  logic w_y;
  logic w_d;
  logic w_bnext;

  // Two cascaded half subtractors: x-y first, then subtract the incoming borrow.
  assign w_x     = r_sa[0];
  assign w_y     = r_sb[0];
  assign w_d     = w_x ^ w_y ^ r_br;
  assign w_bnext = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_diff  <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_bout  <= 1'b0;
      r_dser  <= 1'b0;
      r_dv    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_dser <= w_d;
          r_dv   <= 1'b1;
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_sa   <= r_sa >> 1;
          r_sb   <= r_sb >> 1;
          r_br   <= w_bnext;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_bout  <= w_bnext;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_dv    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state == RUN) || (r_state == DONE);
  assign done        = (r_state == DONE);
  assign diff        = r_diff;
  assign bout        = r_bout;
  assign d_ser       = r_dser;
  assign d_ser_valid = r_dv;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and random operations against an arithmetic model of serial_sub.
module tb_serial_sub;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         d_ser;
  logic         d_ser_valid;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] prev_diff;
  logic         prev_b;

  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout),
    .d_ser(d_ser), .d_ser_valid(d_ser_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One operation: start sampled at the first edge, bits follow LSB first,
  // done with the last bit, back to idle on the edge after.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input bit noise, input bit hold);
    logic [W-1:0] ed;
    logic         eb;
    ed = ta - tb_v;
    eb = (ta < tb_v);
    start = 1'b1;
    a = ta;
    b = tb_v;
    tick;
    if (!hold) start = 1'b0;
    if (noise) begin a = W'($urandom); b = W'($urandom); end
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    chk("dv_after_start", d_ser_valid, 0);
    chk("diff_held", diff, prev_diff);
    chk("bout_held", bout, prev_b);
    for (int i = 0; i < W; i++) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        a = W'($urandom);
        b = W'($urandom);
      end
      tick;
      chk($sformatf("dser_bit%0d", i), d_ser, ed[i]);
      chk($sformatf("dv_bit%0d", i), d_ser_valid, 1);
      chk($sformatf("busy_bit%0d", i), busy, 1);
      chk($sformatf("done_bit%0d", i), done, (i == W - 1) ? 1 : 0);
    end
    chk("diff_final", diff, ed);
    chk("bout_final", bout, eb);
    if (noise) start = 1'b1;
    tick;
    if (!hold) start = 1'b0;
    chk("busy_idle", busy, 0);
    chk("done_idle", done, 0);
    chk("dv_idle", d_ser_valid, 0);
    chk("diff_idle", diff, ed);
    chk("bout_idle", bout, eb);
    prev_diff = ed;
    prev_b    = eb;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    prev_diff = '0;
    prev_b = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dv", d_ser_valid, 0);
    chk("rst_dser", d_ser, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    tick;
    tick;
    rst = 1'b0;

    // Directed cases
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op(8'h10, 8'h20, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, 1'b0, 1'b0);
    run_op(8'hFF, 8'h00, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 1'b0);

    tick;
    chk("idle_busy", busy, 0);
    chk("idle_diff", diff, prev_diff);

    // Asynchronous reset in the middle of a run
    start = 1'b1;
    a = 8'h55;
    b = 8'h0A;
    tick;
    start = 1'b0;
    repeat (4) tick;
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dv", d_ser_valid, 0);
    chk("abort_dser", d_ser, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    tick;
    chk("abort_hold_done", done, 0);
    rst = 1'b0;
    prev_diff = '0;
    prev_b = 1'b0;
    run_op(8'h03, 8'h05, 1'b0, 1'b0);

    // Start held high: back-to-back acceptance every W+2 edges
    run_op(8'h09, 8'h04, 1'b0, 1'b1);
    run_op(8'h09, 8'h04, 1'b0, 1'b1);
    run_op(8'h09, 8'h04, 1'b0, 1'b0);

    // Random operations, some with spurious start/operand activity while busy
    for (int k = 0; k < 20; k++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 1) == 1) tick;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
